// File: rtl/pipeline_controller.sv
// Hazard and trap sequencer for the 5-stage core.
// Arbitrates stalls/flushes and walks trap entry: drain, flush, commit.
module pipeline_controller #(
   parameter int FLUSH_CYCLES = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        exception_illegal_instruction_i,
   input  logic        exception_breakpoint_i,
   input  logic        exception_env_call_from_M_mode_i,
   input  logic [31:0] program_counter_decode_stage_i,
   input  logic        en_flush_mret_instruction_i,
   input  logic        en_stall_decode_stage_i,
   input  logic        branch_mispredict_i,
   input  logic        stall_mem_i,
   input  logic        exception_load_misaligned_i,
   input  logic        exception_store_misaligned_i,
   input  logic [31:0] exception_mem_adress_i,
   input  logic [31:0] program_counter_mem_stage_i,
   output logic        stall_fetch_stage_o,
   output logic        stall_decode_stage_o,
   output logic        stall_execute_stage_o,
   output logic        flush_fetch_stage_o,
   output logic        flush_decode_stage_o,
   output logic        flush_execute_stage_o,
   output logic        en_exception_o,
   output logic [2:0]  exception_cause_o,
   output logic [31:0] exception_adress_o,
   output logic [31:0] exception_program_counter_o
);

   localparam int CW = $clog2(FLUSH_CYCLES + 1);

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      FLUSH,
      TRAP
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    cause_q, cause_d;
   logic [31:0]   adr_q, adr_d;
   logic [31:0]   pc_q, pc_d;
   logic          exc_q, exc_d;

   logic          mem_exc;
   logic [2:0]    mem_cause;
   logic          dec_exc;
   logic [2:0]    dec_cause;

   always_comb begin
      mem_exc   = exception_load_misaligned_i
                | exception_store_misaligned_i;
      mem_cause = exception_load_misaligned_i ? 3'd3 : 3'd4;
      dec_exc   = exception_illegal_instruction_i
                | exception_breakpoint_i
                | exception_env_call_from_M_mode_i;
      if (exception_illegal_instruction_i)
         dec_cause = 3'd0;
      else if (exception_breakpoint_i)
         dec_cause = 3'd1;
      else
         dec_cause = 3'd2;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cause_d = cause_q;
      adr_d   = adr_q;
      pc_d    = pc_q;
      exc_d   = 1'b0;
      stall_fetch_stage_o   = 1'b0;
      stall_decode_stage_o  = 1'b0;
      stall_execute_stage_o = 1'b0;
      flush_fetch_stage_o   = 1'b0;
      flush_decode_stage_o  = 1'b0;
      flush_execute_stage_o = 1'b0;

      unique case (state_q)
         RUN: begin
            if (mem_exc) begin
               cause_d = mem_cause;
               adr_d   = exception_mem_adress_i;
               pc_d    = program_counter_mem_stage_i;
               cnt_d   = '0;
               state_d = FLUSH;
            end else if (branch_mispredict_i) begin
               // wrong-path decode events are dropped here
               flush_fetch_stage_o  = 1'b1;
               flush_decode_stage_o = 1'b1;
            end else if (stall_mem_i) begin
               stall_fetch_stage_o   = 1'b1;
               stall_decode_stage_o  = 1'b1;
               stall_execute_stage_o = 1'b1;
               if (dec_exc) begin
                  cause_d = dec_cause;
                  adr_d   = '0;
                  pc_d    = program_counter_decode_stage_i;
                  state_d = DRAIN;
               end
            end else if (dec_exc) begin
               cause_d = dec_cause;
               adr_d   = '0;
               pc_d    = program_counter_decode_stage_i;
               cnt_d   = '0;
               state_d = FLUSH;
            end else if (en_flush_mret_instruction_i) begin
               flush_fetch_stage_o  = 1'b1;
               flush_decode_stage_o = 1'b1;
            end else if (en_stall_decode_stage_i) begin
               stall_fetch_stage_o = 1'b1;
            end
         end

         DRAIN: begin
            stall_fetch_stage_o   = 1'b1;
            stall_decode_stage_o  = 1'b1;
            stall_execute_stage_o = 1'b1;
            // an older mem fault replaces the pending decode trap
            if (mem_exc) begin
               cause_d = mem_cause;
               adr_d   = exception_mem_adress_i;
               pc_d    = program_counter_mem_stage_i;
               cnt_d   = '0;
               state_d = FLUSH;
            end else if (!stall_mem_i) begin
               cnt_d   = '0;
               state_d = FLUSH;
            end
         end

         FLUSH: begin
            stall_fetch_stage_o   = 1'b1;
            flush_fetch_stage_o   = 1'b1;
            flush_decode_stage_o  = 1'b1;
            flush_execute_stage_o = 1'b1;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(FLUSH_CYCLES - 1)) begin
               state_d = TRAP;
               exc_d   = 1'b1;
            end
         end

         TRAP: begin
            stall_fetch_stage_o   = 1'b1;
            flush_fetch_stage_o   = 1'b1;
            flush_decode_stage_o  = 1'b1;
            flush_execute_stage_o = 1'b1;
            state_d = RUN;
         end

         default: state_d = RUN;
      endcase

      if (rst_i) begin
         stall_fetch_stage_o   = 1'b0;
         stall_decode_stage_o  = 1'b0;
         stall_execute_stage_o = 1'b0;
         flush_fetch_stage_o   = 1'b1;
         flush_decode_stage_o  = 1'b1;
         flush_execute_stage_o = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= RUN;
         cnt_q   <= '0;
         cause_q <= '0;
         adr_q   <= '0;
         pc_q    <= '0;
         exc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cause_q <= cause_d;
         adr_q   <= adr_d;
         pc_q    <= pc_d;
         exc_q   <= exc_d;
      end
   end

   assign en_exception_o              = exc_q;
   assign exception_cause_o           = cause_q;
   assign exception_adress_o          = adr_q;
   assign exception_program_counter_o = pc_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Randomised bench for pipeline_controller.
// Trap commits go through a scoreboard queue checked by a monitor.
module tb_pipeline_controller;

   localparam int FC = 2;

   typedef struct {
      logic        rst;
      logic        ill;
      logic        bp;
      logic        ecall;
      logic [31:0] dpc;
      logic        mret;
      logic        sdec;
      logic        misp;
      logic        smem;
      logic        lmis;
      logic        smis;
      logic [31:0] madr;
      logic [31:0] mpc;
   } stim_t;

   typedef struct {
      int          cyc;
      logic [2:0]  cause;
      logic [31:0] adr;
      logic [31:0] pc;
   } trap_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        ill, bp, ecall, mret, sdec, misp, smem, lmis, smis;
   logic [31:0] dpc, madr, mpc;
   logic        sf, sd, se, ff, fd, fe, en_exc;
   logic [2:0]  cause;
   logic [31:0] adr, pc;

   always #5 clk = ~clk;

   pipeline_controller #(.FLUSH_CYCLES(FC)) dut (
      .clk_i                            (clk),
      .rst_i                            (rst),
      .exception_illegal_instruction_i  (ill),
      .exception_breakpoint_i           (bp),
      .exception_env_call_from_M_mode_i (ecall),
      .program_counter_decode_stage_i   (dpc),
      .en_flush_mret_instruction_i      (mret),
      .en_stall_decode_stage_i          (sdec),
      .branch_mispredict_i              (misp),
      .stall_mem_i                      (smem),
      .exception_load_misaligned_i      (lmis),
      .exception_store_misaligned_i     (smis),
      .exception_mem_adress_i           (madr),
      .program_counter_mem_stage_i      (mpc),
      .stall_fetch_stage_o              (sf),
      .stall_decode_stage_o             (sd),
      .stall_execute_stage_o            (se),
      .flush_fetch_stage_o              (ff),
      .flush_decode_stage_o             (fd),
      .flush_execute_stage_o            (fe),
      .en_exception_o                   (en_exc),
      .exception_cause_o                (cause),
      .exception_adress_o               (adr),
      .exception_program_counter_o      (pc)
   );

   int    n_checks = 0;
   int    n_fail   = 0;
   int    cyc      = 0;
   trap_t exp_q[$];

   // reference model: a trap window is just a commit cycle number
   bit          draining   = 0;
   int          commit_cyc = -1;
   bit          held_known = 0;
   logic [2:0]  m_cause = '0;
   logic [31:0] m_adr   = '0;
   logic [31:0] m_pc    = '0;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d: got %h expected %h",
                  name, cyc, act, exp);
      end
   endtask

   function automatic stim_t idle_s();
      stim_t s;
      s.rst = 0; s.ill = 0; s.bp = 0; s.ecall = 0;
      s.dpc = '0; s.mret = 0; s.sdec = 0; s.misp = 0;
      s.smem = 0; s.lmis = 0; s.smis = 0;
      s.madr = '0; s.mpc = '0;
      return s;
   endfunction

   task automatic push_trap();
      trap_t t;
      t.cyc = cyc; t.cause = m_cause; t.adr = m_adr; t.pc = m_pc;
      exp_q.push_back(t);
   endtask

   task automatic capture(input logic [2:0] c,
                          input logic [31:0] a,
                          input logic [31:0] p);
      m_cause = c; m_adr = a; m_pc = p;
   endtask

   task automatic step(input stim_t s);
      logic [5:0]  e;
      logic [2:0]  h_c;
      logic [31:0] h_a, h_p;
      bit          chk_h;
      bit          mem, dec;
      logic [2:0]  mc, dc;
      @(posedge clk);
      #1;
      rst = s.rst; ill = s.ill; bp = s.bp; ecall = s.ecall;
      dpc = s.dpc; mret = s.mret; sdec = s.sdec; misp = s.misp;
      smem = s.smem; lmis = s.lmis; smis = s.smis;
      madr = s.madr; mpc = s.mpc;
      cyc++;
      h_c = m_cause; h_a = m_adr; h_p = m_pc; chk_h = held_known;
      mem = s.lmis | s.smis;
      mc  = s.lmis ? 3'd3 : 3'd4;
      dec = s.ill | s.bp | s.ecall;
      dc  = s.ill ? 3'd0 : (s.bp ? 3'd1 : 3'd2);
      e   = '0; // {sf,sd,se,ff,fd,fe}
      if (s.rst) begin
         e = 6'b000111;
         if (!draining && cyc == commit_cyc) push_trap();
         draining = 0; commit_cyc = -1;
         capture(3'd0, '0, '0);
         held_known = 1;
      end else if (!draining && cyc <= commit_cyc) begin
         e = 6'b100111;
         if (cyc == commit_cyc) push_trap();
      end else if (draining) begin
         e = 6'b111000;
         if (mem) begin
            capture(mc, s.madr, s.mpc);
            draining = 0; commit_cyc = cyc + 1 + FC;
         end else if (!s.smem) begin
            draining = 0; commit_cyc = cyc + 1 + FC;
         end
      end else if (mem) begin
         capture(mc, s.madr, s.mpc);
         commit_cyc = cyc + 1 + FC;
      end else if (s.misp) begin
         e = 6'b000110;
      end else if (s.smem) begin
         e = 6'b111000;
         if (dec) begin
            capture(dc, '0, s.dpc);
            draining = 1;
         end
      end else if (dec) begin
         capture(dc, '0, s.dpc);
         commit_cyc = cyc + 1 + FC;
      end else if (s.mret) begin
         e = 6'b000110;
      end else if (s.sdec) begin
         e = 6'b100000;
      end
      @(negedge clk);
      check("stall_fetch",   32'(sf), 32'(e[5]));
      check("stall_decode",  32'(sd), 32'(e[4]));
      check("stall_execute", 32'(se), 32'(e[3]));
      check("flush_fetch",   32'(ff), 32'(e[2]));
      check("flush_decode",  32'(fd), 32'(e[1]));
      check("flush_execute", 32'(fe), 32'(e[0]));
      if (chk_h) begin
         check("held_cause", 32'(cause), 32'(h_c));
         check("held_adress", adr, h_a);
         check("held_pc", pc, h_p);
      end
   endtask

   task automatic idles(input int n);
      for (int i = 0; i < n; i++) step(idle_s());
   endtask

   // monitor: every commit pulse must match the oldest expected trap
   initial begin
      trap_t t;
      forever begin
         @(negedge clk);
         if (en_exc === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_trap cyc=%0d: got 1 expected 0",
                        cyc);
            end else begin
               t = exp_q.pop_front();
               check("trap_cycle", 32'(cyc), 32'(t.cyc));
               check("trap_cause", 32'(cause), 32'(t.cause));
               check("trap_adress", adr, t.adr);
               check("trap_pc", pc, t.pc);
            end
         end
      end
   end

   initial begin
      stim_t s;
      s = idle_s();
      s.rst = 1;
      step(s);
      step(s);
      step(idle_s());
      check("reset_en_exception", 32'(en_exc), 32'd0);
      check("reset_cause", 32'(cause), 32'd0);
      idles(2);

      // illegal at 0x100
      s = idle_s(); s.ill = 1; s.dpc = 32'h100;
      step(s);
      idles(5);

      // load-misaligned beats a same-cycle ecall
      s = idle_s(); s.lmis = 1; s.madr = 32'h2003;
      s.mpc = 32'h80; s.ecall = 1; s.dpc = 32'h44;
      step(s);
      idles(5);

      // ecall captured under a memory stall, then drain
      s = idle_s(); s.ecall = 1; s.dpc = 32'h40; s.smem = 1;
      step(s);
      s = idle_s(); s.smem = 1;
      step(s); step(s); step(s);
      idles(6);

      // store-misaligned in DRAIN overrides the pending ecall
      s = idle_s(); s.ecall = 1; s.dpc = 32'h40; s.smem = 1;
      step(s);
      s = idle_s(); s.smem = 1; s.smis = 1;
      s.mpc = 32'h3C; s.madr = 32'h11;
      step(s);
      idles(6);

      // mispredict kills a same-cycle illegal; mret alone
      s = idle_s(); s.misp = 1; s.ill = 1; s.dpc = 32'h200;
      step(s);
      idles(2);
      s = idle_s(); s.mret = 1;
      step(s);
      idles(4);

      // reset in FLUSH aborts the trap
      s = idle_s(); s.bp = 1; s.dpc = 32'h300;
      step(s);
      step(idle_s());
      s = idle_s(); s.rst = 1;
      step(s);
      step(idle_s());
      check("abort_cause", 32'(cause), 32'd0);
      check("abort_pc", pc, 32'd0);
      idles(5);

      for (int i = 0; i < 4000; i++) begin
         s = idle_s();
         s.rst   = ($urandom_range(0, 199) == 0);
         s.ill   = ($urandom_range(0, 99) < 5);
         s.bp    = ($urandom_range(0, 99) < 5);
         s.ecall = ($urandom_range(0, 99) < 5);
         s.dpc   = $urandom();
         s.mret  = ($urandom_range(0, 99) < 5);
         s.sdec  = ($urandom_range(0, 99) < 10);
         s.misp  = ($urandom_range(0, 99) < 8);
         s.smem  = ($urandom_range(0, 99) < 25);
         s.lmis  = ($urandom_range(0, 99) < 4);
         s.smis  = ($urandom_range(0, 99) < 4);
         s.madr  = $urandom();
         s.mpc   = $urandom();
         step(s);
      end

      idles(12);
      check("pending_traps", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
